// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct codes, ALU operation codes, the
// multicycle controller state encoding and the instruction class set.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_NOP     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_SYSCALL = 3'd5,
    ST_HALT    = 3'd6,
    ST_TRAP    = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_JAL,
    CL_JR,
    CL_SYSCALL,
    CL_ILLEGAL
  } iclass_e;

  // Funct field to ALU operation for the supported R-type arithmetic group.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    logic [2:0] op;
    op = ALU_ADD;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: maps the registered instruction word
// to an instruction class plus the ALU operation and ALU source it needs.
module instr_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_e     iclass,
  output logic [2:0]  aluop,
  output logic        alusrc
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ir_unused;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign ir_unused = ^ir[25:6];

  // Anything not listed stays CL_ILLEGAL; the controller decides what that means.
  always_comb begin
    iclass = CL_ILLEGAL;
    aluop  = ALU_AND;
    alusrc = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_NOP:     iclass = CL_NOP;
          FN_JR:      iclass = CL_JR;
          FN_SYSCALL: iclass = CL_SYSCALL;
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            iclass = CL_ALU_R;
            aluop  = alu_for_funct(funct);
          end
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_J:   iclass = CL_JUMP;
      OP_JAL: iclass = CL_JAL;
      OP_BEQ, OP_BNE: begin
        iclass = CL_BRANCH;
        aluop  = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_LUI: begin
        iclass = CL_ALU_I;
        aluop  = ALU_ADD;
        alusrc = 1'b1;
      end
      OP_SLTIU: begin
        iclass = CL_ALU_I;
        aluop  = ALU_SLT;
        alusrc = 1'b1;
      end
      OP_ORI: begin
        iclass = CL_ALU_I;
        aluop  = ALU_OR;
        alusrc = 1'b1;
      end
      OP_LW: begin
        iclass = CL_LOAD;
        aluop  = ALU_ADD;
        alusrc = 1'b1;
      end
      OP_SW: begin
        iclass = CL_STORE;
        aluop  = ALU_ADD;
        alusrc = 1'b1;
      end
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM with syscall handshake and timeout.
// Optional macro ILLEGAL_TRAP_EN: unsupported instructions trap instead of acting as NOP.
module mc_control
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYS_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] vreg,
  input  logic              sys_ack,
  output logic [1:0]        RegDst,
  output logic              Jump,
  output logic              Branch,
  output logic              MemRead,
  output logic              MemToReg,
  output logic [2:0]        ALUop,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemWrite,
  output logic              JumpLink,
  output logic              JumpReg,
  output logic              ir_load,
  output logic              syscall_req,
  output logic              sys_timeout,
  output logic              halt,
  output logic              illegal,
  output logic [2:0]        state
);

  localparam int                CNT_W    = $clog2(SYS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYS_TIMEOUT - 1);

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = ST_TRAP;
`else
  localparam state_e ILL_NEXT = ST_FETCH;
`endif

  state_e           state_q;
  state_e           state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] cnt_q;
  iclass_e          iclass;
  logic [2:0]       dec_aluop;
  logic             dec_alusrc;

  instr_decode u_decode (
    .ir     (ir_q),
    .iclass (iclass),
    .aluop  (dec_aluop),
    .alusrc (dec_alusrc)
  );

  // The syscall counter sits at zero outside SYSCALL, so it is clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && instr_valid)
        ir_q <= instr;
      if (state_q == ST_SYSCALL)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    RegDst      = 2'b00;
    Jump        = 1'b0;
    Branch      = 1'b0;
    MemRead     = 1'b0;
    MemToReg    = 1'b0;
    ALUop       = 3'b000;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    MemWrite    = 1'b0;
    JumpLink    = 1'b0;
    JumpReg     = 1'b0;
    ir_load     = 1'b0;
    syscall_req = 1'b0;
    sys_timeout = 1'b0;
    halt        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_load = instr_valid;
        if (instr_valid)
          state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (iclass)
          CL_NOP:     state_d = ST_FETCH;
          CL_SYSCALL: state_d = ST_SYSCALL;
          CL_ILLEGAL: state_d = ILL_NEXT;
          default:    state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        ALUop   = dec_aluop;
        ALUSrc  = dec_alusrc;
        state_d = ST_FETCH;
        case (iclass)
          CL_BRANCH: Branch = 1'b1;
          CL_JUMP:   Jump   = 1'b1;
          CL_JAL: begin
            Jump     = 1'b1;
            JumpLink = 1'b1;
            RegDst   = 2'b10;
            RegWrite = 1'b1;
          end
          CL_JR:              JumpReg = 1'b1;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          CL_ALU_R, CL_ALU_I: state_d = ST_WB;
          default:            state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        ALUop    = ALU_ADD;
        ALUSrc   = 1'b1;
        MemRead  = (iclass == CL_LOAD);
        MemWrite = (iclass == CL_STORE);
        if (mem_ready)
          state_d = (iclass == CL_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (iclass == CL_ALU_R) ? 2'b01 : 2'b00;
        MemToReg = (iclass == CL_LOAD);
        ALUop    = dec_aluop;
        ALUSrc   = dec_alusrc;
        state_d  = ST_FETCH;
      end
      // An ack on the final counted cycle still wins over the timeout.
      ST_SYSCALL: begin
        syscall_req = 1'b1;
        if (sys_ack) begin
          state_d = (vreg == DATA_W'(10)) ? ST_HALT : ST_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          sys_timeout = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_HALT: halt = 1'b1;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == ST_TRAP);
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus random instruction
// streams, compared cycle by cycle against a mnemonic-level behavioural model.
module tb_mc_control;

  localparam int DATA_W      = 32;
  localparam int SYS_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] vreg;
  logic              sys_ack;
  logic [1:0]        RegDst;
  logic              Jump, Branch, MemRead, MemToReg, RegWrite, ALUSrc;
  logic              MemWrite, JumpLink, JumpReg;
  logic [2:0]        ALUop;
  logic              ir_load, syscall_req, sys_timeout, halt, illegal;
  logic [2:0]        state;

  always #5 clk = ~clk;

  mc_control #(.DATA_W(DATA_W), .SYS_TIMEOUT(SYS_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .mem_ready   (mem_ready),
    .vreg        (vreg),
    .sys_ack     (sys_ack),
    .RegDst      (RegDst),
    .Jump        (Jump),
    .Branch      (Branch),
    .MemRead     (MemRead),
    .MemToReg    (MemToReg),
    .ALUop       (ALUop),
    .RegWrite    (RegWrite),
    .ALUSrc      (ALUSrc),
    .MemWrite    (MemWrite),
    .JumpLink    (JumpLink),
    .JumpReg     (JumpReg),
    .ir_load     (ir_load),
    .syscall_req (syscall_req),
    .sys_timeout (sys_timeout),
    .halt        (halt),
    .illegal     (illegal),
    .state       (state)
  );

  typedef struct packed {
    logic [1:0] regdst;
    logic       jump, branch, memread, memtoreg;
    logic [2:0] aluop;
    logic       regwrite, alusrc, memwrite, jumplink, jumpreg;
    logic       irload, sysreq, systmo, halt, illegal;
    logic [2:0] st;
  } ctl_t;

  typedef struct packed {
    logic        iv;
    logic [31:0] instr;
    logic        mr;
    logic        ack;
    logic [31:0] vreg;
    ctl_t        exp;
  } step_t;

  ctl_t  obs;
  step_t prog[$];
  int    nChecks = 0;
  int    nPass   = 0;
  string testName;

  assign obs = {RegDst, Jump, Branch, MemRead, MemToReg, ALUop, RegWrite, ALUSrc,
                MemWrite, JumpLink, JumpReg, ir_load, syscall_req, sys_timeout,
                halt, illegal, state};

  function automatic ctl_t stateOnly(input int st);
    ctl_t c;
    c    = '0;
    c.st = 3'(st);
    return c;
  endfunction

  function automatic void push(input logic iv, input logic [31:0] w, input logic mr,
                               input logic ack, input logic [31:0] vr, input ctl_t e);
    step_t s;
    s.iv = iv; s.instr = w; s.mr = mr; s.ack = ack; s.vreg = vr; s.exp = e;
    prog.push_back(s);
  endfunction

  function automatic void pushQuiet(input ctl_t e);
    push(1'b0, $urandom, 1'b0, 1'b0, $urandom, e);
  endfunction

  // Inputs that the current state must ignore are driven with random noise.
  function automatic void pushNoisy(input ctl_t e, input bit hs);
    push(1'($urandom), $urandom, hs ? 1'($urandom) : 1'b0,
         hs ? 1'($urandom) : 1'b0, $urandom, e);
  endfunction

  function automatic string mnemonic(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h00:   return "NOP";
        6'h08:   return "JR";
        6'h0C:   return "SYSCALL";
        6'h20:   return "ADD";
        6'h21:   return "ADDU";
        6'h22:   return "SUB";
        6'h24:   return "AND";
        6'h25:   return "OR";
        6'h2A:   return "SLT";
        default: return "ILL";
      endcase
    end
    case (op)
      6'h02:   return "J";
      6'h03:   return "JAL";
      6'h04:   return "BEQ";
      6'h05:   return "BNE";
      6'h08:   return "ADDI";
      6'h09:   return "ADDIU";
      6'h0B:   return "SLTIU";
      6'h0D:   return "ORI";
      6'h0F:   return "LUI";
      6'h23:   return "LW";
      6'h2B:   return "SW";
      default: return "ILL";
    endcase
  endfunction

  function automatic int aluFor(input string m);
    if (m == "SUB" || m == "BEQ" || m == "BNE") return 6;
    if (m == "AND") return 0;
    if (m == "OR" || m == "ORI") return 1;
    if (m == "SLT" || m == "SLTIU") return 7;
    return 2;
  endfunction

  function automatic bit isImm(input string m);
    return (m == "ADDI" || m == "ADDIU" || m == "LUI" || m == "ORI" ||
            m == "SLTIU" || m == "LW" || m == "SW");
  endfunction

  // Expected cycle-by-cycle trace for one instruction, starting in FETCH.
  task automatic addInstr(input logic [31:0] w, input int memLat, input int ackDelay,
                          input logic [31:0] vr, input int idle, output bit terminal);
    string m;
    ctl_t  e;
    int    alu;
    bit    imm;
    m        = mnemonic(w);
    alu      = aluFor(m);
    imm      = isImm(m);
    terminal = 1'b0;
    for (int i = 0; i < idle; i++) pushQuiet(stateOnly(0));
    e = stateOnly(0); e.irload = 1'b1;
    push(1'b1, w, 1'b0, 1'b0, $urandom, e);
    pushNoisy(stateOnly(1), 1'b0);
    if (m == "NOP") begin
    end else if (m == "ILL") begin
`ifdef ILLEGAL_TRAP_EN
      e = stateOnly(7); e.illegal = 1'b1;
      repeat (3) pushNoisy(e, 1'b1);
      terminal = 1'b1;
`endif
    end else if (m == "SYSCALL") begin
      e = stateOnly(5); e.sysreq = 1'b1;
      if (ackDelay < SYS_TIMEOUT) begin
        for (int i = 0; i < ackDelay; i++) pushNoisy(e, 1'b0);
        push(1'b0, $urandom, 1'b0, 1'b1, vr, e);
        if (vr == 32'd10) begin
          e = stateOnly(6); e.halt = 1'b1;
          repeat (3) pushNoisy(e, 1'b1);
          terminal = 1'b1;
        end
      end else begin
        for (int i = 0; i < SYS_TIMEOUT - 1; i++) pushNoisy(e, 1'b0);
        e.systmo = 1'b1;
        pushNoisy(e, 1'b0);
      end
    end else if (m == "LW" || m == "SW") begin
      e = stateOnly(2); e.aluop = 3'(alu); e.alusrc = 1'b1;
      pushNoisy(e, 1'b0);
      e = stateOnly(3); e.aluop = 3'b010; e.alusrc = 1'b1;
      if (m == "LW") e.memread = 1'b1; else e.memwrite = 1'b1;
      for (int i = 0; i < memLat; i++) pushNoisy(e, 1'b0);
      push(1'b0, $urandom, 1'b1, 1'b0, $urandom, e);
      if (m == "LW") begin
        e = stateOnly(4); e.regwrite = 1'b1; e.memtoreg = 1'b1;
        e.aluop = 3'b010; e.alusrc = 1'b1;
        pushNoisy(e, 1'b0);
      end
    end else if (m == "BEQ" || m == "BNE") begin
      e = stateOnly(2); e.aluop = 3'b110; e.branch = 1'b1;
      pushNoisy(e, 1'b0);
    end else if (m == "J") begin
      e = stateOnly(2); e.jump = 1'b1;
      pushNoisy(e, 1'b0);
    end else if (m == "JAL") begin
      e = stateOnly(2); e.jump = 1'b1; e.jumplink = 1'b1; e.regdst = 2'd2; e.regwrite = 1'b1;
      pushNoisy(e, 1'b0);
    end else if (m == "JR") begin
      e = stateOnly(2); e.jumpreg = 1'b1;
      pushNoisy(e, 1'b0);
    end else begin
      e = stateOnly(2); e.aluop = 3'(alu); e.alusrc = imm;
      pushNoisy(e, 1'b0);
      e = stateOnly(4); e.aluop = 3'(alu); e.alusrc = imm; e.regwrite = 1'b1;
      e.regdst = imm ? 2'd0 : 2'd1;
      pushNoisy(e, 1'b0);
    end
  endtask

  task automatic applyStimulus(input step_t s);
    instr_valid = s.iv;
    instr       = s.instr;
    mem_ready   = s.mr;
    sys_ack     = s.ack;
    vreg        = s.vreg;
  endtask

  task automatic checkOutput(input string tag, input ctl_t exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %h expected %h (state %0d vs %0d)",
                tag, obs, exp, obs.st, exp.st);
  endtask

  task automatic runSteps(input int n);
    step_t s;
    for (int k = 0; k < n && prog.size() > 0; k++) begin
      s = prog.pop_front();
      @(negedge clk);
      applyStimulus(s);
      #1;
      checkOutput($sformatf("%s.step%0d", testName, k), s.exp);
    end
  endtask

  task automatic runAll();
    runSteps(prog.size());
  endtask

  // Reset lands between clock edges; outputs must collapse without waiting for a clock.
  task automatic asyncReset(input string tag);
    ctl_t e;
    bit   iv;
    iv = 1'($urandom);
    #1;
    instr_valid = iv;
    mem_ready   = 1'b0;
    sys_ack     = 1'b0;
    rst_n       = 1'b0;
    #1;
    e = stateOnly(0); e.irload = iv;
    checkOutput({tag, ".async"}, e);
    @(posedge clk); #1;
    checkOutput({tag, ".held"}, e);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    prog.delete();
  endtask

  initial begin
    bit          term;
    ctl_t        e;
    logic [31:0] w;
    logic [5:0]  ops[11]   = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0B,
                               6'h0D, 6'h0F, 6'h23, 6'h2B};
    logic [5:0]  functs[9] = '{6'h00, 6'h08, 6'h0C, 6'h20, 6'h21, 6'h22, 6'h24,
                               6'h25, 6'h2A};
    int          kind;

    rst_n = 1'b0; instr_valid = 1'b1; instr = 32'h0;
    mem_ready = 1'b0; sys_ack = 1'b0; vreg = '0;
    #3;
    e = stateOnly(0); e.irload = 1'b1;
    checkOutput("reset.irload_follows", e);
    instr_valid = 1'b0;
    #1;
    checkOutput("reset.idle", stateOnly(0));
    @(negedge clk);
    rst_n = 1'b1;

    testName = "add";   addInstr(32'h00221820, 0, 0, 0, 1, term); runAll();
    testName = "lw";    addInstr(32'h8C220004, 3, 0, 0, 0, term); runAll();
    testName = "jal";   addInstr(32'h0C000010, 0, 0, 0, 0, term); runAll();
    testName = "sw0";   addInstr(32'hAC220004, 0, 0, 0, 0, term); runAll();
    testName = "beq";   addInstr(32'h10220003, 0, 0, 0, 0, term); runAll();
    testName = "ori";   addInstr(32'h3422FFFF, 0, 0, 0, 0, term); runAll();
    testName = "jr";    addInstr(32'h03E00008, 0, 0, 0, 0, term); runAll();
    testName = "sysret"; addInstr(32'h0000000C, 0, 2, 32'd4, 0, term); runAll();
    testName = "systmo"; addInstr(32'h0000000C, 0, SYS_TIMEOUT, 32'd10, 0, term); runAll();
    testName = "sysedge"; addInstr(32'h0000000C, 0, SYS_TIMEOUT - 1, 32'd4, 0, term); runAll();
    testName = "ill";   addInstr(32'hFC000000, 0, 0, 0, 0, term); runAll();
    if (term) asyncReset("ill");
    testName = "syshalt"; addInstr(32'h0000000C, 0, 5, 32'd10, 0, term); runAll();
    asyncReset("syshalt");

    testName = "sysrst"; addInstr(32'h0000000C, 0, SYS_TIMEOUT, 0, 0, term);
    runSteps(5);
    asyncReset("sysrst");
    testName = "memrst"; addInstr(32'h8C220004, 5, 0, 0, 0, term);
    runSteps(4);
    asyncReset("memrst");
    testName = "postrst"; addInstr(32'h00221820, 0, 0, 0, 0, term); runAll();

    for (int n = 0; n < 80; n++) begin
      w    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 3)
        w = {6'h00, w[25:6], functs[$urandom_range(0, 8)]};
      else if (kind <= 8)
        w[31:26] = ops[$urandom_range(0, 10)];
      testName = $sformatf("rand%0d_%h", n, w);
      addInstr(w, $urandom_range(0, 4), $urandom_range(0, SYS_TIMEOUT + 1),
               ($urandom_range(0, 2) == 0) ? 32'd10 : 32'($urandom_range(0, 20)),
               $urandom_range(0, 2), term);
      runAll();
      if (term) asyncReset(testName);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
